flow_key_extractor: RTL and testbench

- Terminal receiver for the NetFPGA 64-bit packet stream (`in_data`/`in_ctrl`/`in_wr`/`in_rdy`).
- Sits at the far end of the same interface a packet source drives.
- Parses module header, Ethernet, IPv4 and L4 ports; emits one flow key per IPv4 packet on a valid/ready side port.
- Keeps packet/non-IP/error statistics.
- Pairs with the classifier as its standalone flow-key front end and stream checker.

---
 rtl/flow_key_pkg.sv | 36 +++
 rtl/flow_key_stats.sv | 39 +++
 rtl/flow_key_extractor.sv | 202 ++++++++++++++++++++
 tb/tb_flow_key_extractor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/flow_key_pkg.sv
// Shared types and constants for the NetFPGA flow-key extractor.
package flow_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARSE = 2'd1,
    ST_SKIP  = 2'd2
  } state_e;

  localparam logic [7:0]  CTRL_MODULE_HDR = 8'hFF;
  localparam logic [7:0]  CTRL_BODY       = 8'h00;
  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  VER_IHL_V4      = 8'h45;
  localparam logic [7:0]  PROTO_TCP       = 8'h06;
  localparam logic [7:0]  PROTO_UDP       = 8'h11;

  localparam logic [2:0] WORD_FIRST = 3'd1;
  localparam logic [2:0] WORD_ETH   = 3'd2;
  localparam logic [2:0] WORD_IP    = 3'd3;
  localparam logic [2:0] WORD_ADDR  = 3'd4;
  localparam logic [2:0] WORD_PORTS = 3'd5;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
    logic [15:0] ip_len;
  } flow_key_t;

  function automatic logic has_l4_ports(input logic [7:0] proto);
    return (proto == PROTO_TCP) || (proto == PROTO_UDP);
  endfunction

endpackage

// File: rtl/flow_key_stats.sv
// Packet, non-IPv4 and error counters; each advances by one per strobe and wraps.
module flow_key_stats
  import flow_key_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_inc_i,
  input  logic                 non_ip_inc_i,
  input  logic                 err_inc_i,
  output logic [CNT_WIDTH-1:0] pkt_count_o,
  output logic [CNT_WIDTH-1:0] non_ip_count_o,
  output logic [ERR_WIDTH-1:0] err_count_o
);

  logic [CNT_WIDTH-1:0] pkt_count_q;
  logic [CNT_WIDTH-1:0] non_ip_count_q;
  logic [ERR_WIDTH-1:0] err_count_q;

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q    <= '0;
      non_ip_count_q <= '0;
      err_count_q    <= '0;
    end else begin
      pkt_count_q    <= pkt_count_q + CNT_WIDTH'(pkt_inc_i);
      non_ip_count_q <= non_ip_count_q + CNT_WIDTH'(non_ip_inc_i);
      err_count_q    <= err_count_q + ERR_WIDTH'(err_inc_i);
    end
  end

  assign pkt_count_o    = pkt_count_q;
  assign non_ip_count_o = non_ip_count_q;
  assign err_count_o    = err_count_q;

endmodule

// File: rtl/flow_key_extractor.sv
// Terminal NetFPGA stream sink: parses header/Ethernet/IPv4/L4 words and
// emits one flow key per IPv4 packet on a valid/ready side port.
module flow_key_extractor
  import flow_key_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          in_data,
  input  logic [7:0]           in_ctrl,
  input  logic                 in_wr,
  output logic                 in_rdy,
  output logic                 key_valid,
  input  logic                 key_rdy,
  output logic [31:0]          key_src_ip,
  output logic [31:0]          key_dst_ip,
  output logic [15:0]          key_src_port,
  output logic [15:0]          key_dst_port,
  output logic [7:0]           key_proto,
  output logic [15:0]          key_ip_len,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] non_ip_count,
  output logic [ERR_WIDTH-1:0] err_count
);

  state_e      state_q, state_d;
  logic [2:0]  word_idx_q, word_idx_d;
  logic [15:0] ip_len_q, ip_len_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] dst_hi_q, dst_hi_d;
  flow_key_t   key_q, key_d;
  logic        key_valid_q, key_valid_d;

  logic accept_s, hdr_s, eop_s, ipv4_ok_s;
  logic pkt_inc_s, non_ip_inc_s, err_inc_s, key_load_s;

  // The only stall point is between packets, while an unconsumed key is held.
  assign in_rdy    = !reset && !(state_q == ST_IDLE && key_valid_q && !key_rdy);
  assign accept_s  = in_wr && in_rdy;
  assign hdr_s     = (in_ctrl == CTRL_MODULE_HDR);
  assign eop_s     = (in_ctrl != CTRL_BODY) && !hdr_s;
  assign ipv4_ok_s = (in_data[31:16] == ETHERTYPE_IPV4) && (in_data[15:8] == VER_IHL_V4);

  // State, capture and key registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= WORD_FIRST;
      ip_len_q    <= 16'h0000;
      proto_q     <= 8'h00;
      src_ip_q    <= 32'h0000_0000;
      dst_hi_q    <= 16'h0000;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      ip_len_q    <= ip_len_d;
      proto_q     <= proto_d;
      src_ip_q    <= src_ip_d;
      dst_hi_q    <= dst_hi_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_s) begin
            state_d    = ST_PARSE;
            word_idx_d = WORD_FIRST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PARSE: begin
          if (hdr_s) begin
            word_idx_d = WORD_FIRST;
          end else if ((word_idx_q == WORD_ETH && !ipv4_ok_s) || word_idx_q == WORD_PORTS) begin
            state_d = eop_s ? ST_IDLE : ST_SKIP;
          end else if (eop_s) begin
            state_d = ST_IDLE;
          end else begin
            word_idx_d = word_idx_q + 3'd1;
          end
        end
        ST_SKIP: begin
          if (hdr_s) begin
            state_d    = ST_PARSE;
            word_idx_d = WORD_FIRST;
          end else if (eop_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SKIP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output strobes for the counters and key loader
  always_comb begin
    pkt_inc_s    = 1'b0;
    non_ip_inc_s = 1'b0;
    err_inc_s    = in_wr && !in_rdy;
    key_load_s   = 1'b0;
    if (accept_s) begin
      pkt_inc_s = hdr_s;
      case (state_q)
        ST_IDLE:  err_inc_s = !hdr_s;
        ST_PARSE: begin
          if (hdr_s) begin
            err_inc_s = 1'b1;
          end else if (word_idx_q == WORD_ETH && !ipv4_ok_s) begin
            non_ip_inc_s = 1'b1;
          end else if (word_idx_q == WORD_PORTS) begin
            key_load_s = 1'b1;
          end else begin
            err_inc_s = eop_s;
          end
        end
        ST_SKIP:  err_inc_s = 1'b0;
        default:  err_inc_s = 1'b0;
      endcase
    end else begin
      pkt_inc_s = 1'b0;
    end
  end

  // Field capture and key register next state
  always_comb begin
    ip_len_d    = ip_len_q;
    proto_d     = proto_q;
    src_ip_d    = src_ip_q;
    dst_hi_d    = dst_hi_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    if (accept_s && state_q == ST_PARSE && !hdr_s) begin
      case (word_idx_q)
        WORD_IP: begin
          ip_len_d = in_data[63:48];
          proto_d  = in_data[7:0];
        end
        WORD_ADDR: begin
          src_ip_d = in_data[47:16];
          dst_hi_d = in_data[15:0];
        end
        default: ip_len_d = ip_len_q;
      endcase
    end else begin
      ip_len_d = ip_len_q;
    end
    if (key_load_s) begin
      key_d.src_ip   = src_ip_q;
      key_d.dst_ip   = {dst_hi_q, in_data[63:48]};
      key_d.proto    = proto_q;
      key_d.ip_len   = ip_len_q;
      key_d.src_port = has_l4_ports(proto_q) ? in_data[47:32] : 16'h0000;
      key_d.dst_port = has_l4_ports(proto_q) ? in_data[31:16] : 16'h0000;
      key_valid_d    = 1'b1;
    end else if (key_valid_q && key_rdy) begin
      key_d       = '0;
      key_valid_d = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
  end

  assign key_valid    = key_valid_q;
  assign key_src_ip   = key_q.src_ip;
  assign key_dst_ip   = key_q.dst_ip;
  assign key_src_port = key_q.src_port;
  assign key_dst_port = key_q.dst_port;
  assign key_proto    = key_q.proto;
  assign key_ip_len   = key_q.ip_len;

  flow_key_stats #(
    .CNT_WIDTH(CNT_WIDTH),
    .ERR_WIDTH(ERR_WIDTH)
  ) u_stats (
    .clk           (clk),
    .reset         (reset),
    .pkt_inc_i     (pkt_inc_s),
    .non_ip_inc_i  (non_ip_inc_s),
    .err_inc_i     (err_inc_s),
    .pkt_count_o   (pkt_count),
    .non_ip_count_o(non_ip_count),
    .err_count_o   (err_count)
  );

endmodule

// File: tb/tb_flow_key_extractor.sv
// Directed self-checking bench for flow_key_extractor.
module tb_flow_key_extractor;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic        key_valid;
  logic        key_rdy;
  logic [31:0] key_src_ip, key_dst_ip;
  logic [15:0] key_src_port, key_dst_port;
  logic [7:0]  key_proto;
  logic [15:0] key_ip_len;
  logic [31:0] pkt_count, non_ip_count;
  logic [15:0] err_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  flow_key_extractor #(.CNT_WIDTH(32), .ERR_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .in_wr       (in_wr),
    .in_rdy      (in_rdy),
    .key_valid   (key_valid),
    .key_rdy     (key_rdy),
    .key_src_ip  (key_src_ip),
    .key_dst_ip  (key_dst_ip),
    .key_src_port(key_src_port),
    .key_dst_port(key_dst_port),
    .key_proto   (key_proto),
    .key_ip_len  (key_ip_len),
    .pkt_count   (pkt_count),
    .non_ip_count(non_ip_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_key(input string tag, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] sp, input logic [15:0] dp,
                         input logic [7:0] proto, input logic [15:0] len);
    chk({tag, ".valid"}, 64'(key_valid), 64'd1);
    chk({tag, ".src"},   64'(key_src_ip), 64'(src));
    chk({tag, ".dst"},   64'(key_dst_ip), 64'(dst));
    chk({tag, ".sport"}, 64'(key_src_port), 64'(sp));
    chk({tag, ".dport"}, 64'(key_dst_port), 64'(dp));
    chk({tag, ".proto"}, 64'(key_proto), 64'(proto));
    chk({tag, ".len"},   64'(key_ip_len), 64'(len));
  endtask

  // One accepted word per call; outputs are sampled 1ns after the edge.
  task automatic wr(input logic [63:0] d, input logic [7:0] c);
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
  endtask

  task automatic tcp_front();
    wr(64'h0000_0000_0000_0000, 8'hFF);
    wr(64'h0023_ebf9_6000_0017, 8'h00);
    wr(64'ha440_81e4_0800_4510, 8'h00);
    wr(64'h0058_070e_4000_4006, 8'h00);
    wr(64'hb98d_c06c_7594_93e5, 8'h00);
  endtask

  task automatic udp_front();
    wr(64'h0000_0000_0000_0000, 8'hFF);
    wr(64'h0023_ebf9_6000_0017, 8'h00);
    wr(64'ha440_81e4_0800_4500, 8'h00);
    wr(64'h004c_0000_4000_2c11, 8'h00);
    wr(64'h5edf_5bbd_5e04_c06c, 8'h00);
  endtask

  initial begin
    reset   = 1'b1;
    in_data = 64'h0;
    in_ctrl = 8'h00;
    in_wr   = 1'b0;
    key_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_rdy", 64'(in_rdy), 64'd0);
    chk("rst.key_valid", 64'(key_valid), 64'd0);
    chk("rst.key_src", 64'(key_src_ip), 64'd0);
    chk("rst.pkt", 64'(pkt_count), 64'd0);
    chk("rst.err", 64'(err_count), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst.rdy_after", 64'(in_rdy), 64'd1);

    // TCP packet, ends without EOP (trailing body word leaves it in SKIP)
    key_rdy = 1'b1;
    tcp_front();
    wr(64'hb00e_ce87_0016_cec4, 8'h00);
    chk_key("tcp", 32'hC06C7594, 32'h93E5B00E, 16'hCE87, 16'h0016, 8'h06, 16'h0058);
    chk("tcp.pkt", 64'(pkt_count), 64'd1);
    wr(64'h5018_ffff_1234_0000, 8'h00);
    chk("tcp.cleared", 64'(key_valid), 64'd0);

    // Back-to-back UDP packet started directly by FF
    udp_front();
    wr(64'h7594_007b_007b_0038, 8'h00);
    chk_key("udp", 32'h5BBD5E04, 32'hC06C7594, 16'h007B, 16'h007B, 8'h11, 16'h004C);
    chk("udp.err", 64'(err_count), 64'd0);
    chk("udp.pkt", 64'(pkt_count), 64'd2);
    wr(64'h0, 8'h01);
    chk("udp.cleared_src", 64'(key_src_ip), 64'd0);

    // Held key stalls the sink at the packet boundary
    key_rdy = 1'b0;
    tcp_front();
    wr(64'hb00e_ce87_0016_cec4, 8'h00);
    wr(64'h5018_ffff_1234_0000, 8'h02);
    chk("stall.in_rdy", 64'(in_rdy), 64'd0);
    in_data = 64'h0;
    in_ctrl = 8'hFF;
    in_wr   = 1'b1;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    chk("stall.err", 64'(err_count), 64'd1);
    chk("stall.pkt", 64'(pkt_count), 64'd3);
    chk_key("held", 32'hC06C7594, 32'h93E5B00E, 16'hCE87, 16'h0016, 8'h06, 16'h0058);
    key_rdy = 1'b1;
    #1;
    chk("stall.rdy_comb", 64'(in_rdy), 64'd1);
    udp_front();
    wr(64'h7594_007b_007b_0038, 8'h01);
    chk_key("udp2", 32'h5BBD5E04, 32'hC06C7594, 16'h007B, 16'h007B, 8'h11, 16'h004C);
    chk("udp2.pkt", 64'(pkt_count), 64'd4);

    // IPv6 ethertype: no key, counted as non-IP
    wr(64'h0, 8'hFF);
    wr(64'h0023_ebf9_6000_0017, 8'h00);
    wr(64'ha440_81e4_86dd_6000, 8'h00);
    wr(64'h0000_0000_0000_0000, 8'h00);
    wr(64'h0000_0000_0000_0000, 8'h08);
    chk("v6.non_ip", 64'(non_ip_count), 64'd1);
    chk("v6.no_key", 64'(key_valid), 64'd0);

    // Following IPv4 ICMP packet: ports forced to zero, EOP on word 5
    wr(64'h0, 8'hFF);
    wr(64'h0023_ebf9_6000_0017, 8'h00);
    wr(64'ha440_81e4_0800_4510, 8'h00);
    wr(64'h0058_070e_4000_4001, 8'h00);
    wr(64'hb98d_c06c_7594_93e5, 8'h00);
    wr(64'hb00e_ce87_0016_cec4, 8'h01);
    chk_key("icmp", 32'hC06C7594, 32'h93E5B00E, 16'h0000, 16'h0000, 8'h01, 16'h0058);

    // Short packet: EOP on word 3
    wr(64'h0, 8'hFF);
    wr(64'h0023_ebf9_6000_0017, 8'h00);
    wr(64'ha440_81e4_0800_4510, 8'h00);
    wr(64'h0058_070e_4000_4006, 8'h80);
    chk("short.err", 64'(err_count), 64'd2);
    chk("short.no_key", 64'(key_valid), 64'd0);
    chk("short.pkt", 64'(pkt_count), 64'd7);
    wr(64'h1111_2222_3333_4444, 8'h00);
    chk("short.idle_err", 64'(err_count), 64'd3);

    // Reset mid-PARSE discards the partial packet
    tcp_front();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.in_rdy", 64'(in_rdy), 64'd0);
    chk("mid.pkt", 64'(pkt_count), 64'd0);
    chk("mid.err", 64'(err_count), 64'd0);
    chk("mid.non_ip", 64'(non_ip_count), 64'd0);
    chk("mid.key_valid", 64'(key_valid), 64'd0);
    reset = 1'b0;
    #1;
    wr(64'hb00e_ce87_0016_cec4, 8'h00);
    chk("mid.after_err", 64'(err_count), 64'd1);
    chk("mid.after_key", 64'(key_valid), 64'd0);
    chk("mid.after_src", 64'(key_src_ip), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
